// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M encodings for the multi-cycle multiply/divide unit.
// SELECT = {func3, func7[0], func7[5]}; every M-extension op carries 2'b10 in the low bits.
package muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] SEL_M_EXT = 2'b10;

  localparam logic [4:0] SEL_MUL    = {F3_MUL,    SEL_M_EXT};
  localparam logic [4:0] SEL_MULH   = {F3_MULH,   SEL_M_EXT};
  localparam logic [4:0] SEL_MULHSU = {F3_MULHSU, SEL_M_EXT};
  localparam logic [4:0] SEL_MULHU  = {F3_MULHU,  SEL_M_EXT};
  localparam logic [4:0] SEL_DIV    = {F3_DIV,    SEL_M_EXT};
  localparam logic [4:0] SEL_DIVU   = {F3_DIVU,   SEL_M_EXT};
  localparam logic [4:0] SEL_REM    = {F3_REM,    SEL_M_EXT};
  localparam logic [4:0] SEL_REMU   = {F3_REMU,   SEL_M_EXT};

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  function automatic logic sel_valid(input logic [4:0] sel);
    return sel[1:0] == SEL_M_EXT;
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed1(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_signed2(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration: shift-add multiply step or restoring divide step.
// acc/low form a 64-bit working register: {product_hi, product_lo} or {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_unit_pkg::*;
(
  input  step_mode_e  mode,
  input  logic [31:0] acc,
  input  logic [31:0] low,
  input  logic [31:0] operand,
  output logic [31:0] acc_next,
  output logic [31:0] low_next
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    acc_next = acc;
    low_next = low;
    if (mode == STEP_MUL) begin
      // Add the multiplicand when the current multiplier bit is set, then shift right.
      sum      = {1'b0, acc} + (low[0] ? {1'b0, operand} : 33'd0);
      acc_next = sum[32:1];
      low_next = {sum[0], low[31:1]};
    end else begin
      // Bring in the next dividend bit; keep the difference only if it did not borrow.
      rem_sh = {acc, low[31]};
      diff   = rem_sh - {1'b0, operand};
      if (!diff[32]) begin
        acc_next = diff[31:0];
        low_next = {low[30:0], 1'b1};
      end else begin
        acc_next = rem_sh[31:0];
        low_next = {low[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M unit: 32 unsigned iterations plus one sign/special-case fix-up cycle.
// Handshake: START is taken only in IDLE or DONE with a valid code; BUSY covers CALC+FIX; DONE pulses with RESULT.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [4:0]  SELECT,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q;
  logic [2:0]  func3_q;
  logic [31:0] a_q, b_q, op_q, acc_q, low_q;
  logic        neg1_q, neg2_q;

  logic        accept;
  logic        neg1_in, neg2_in;
  logic [31:0] mag1_in, mag2_in;
  logic [31:0] acc_n, low_n;
  logic [31:0] fix_result;
  step_mode_e  mode;

  assign accept = START && sel_valid(SELECT) && (state_q == S_IDLE || state_q == S_DONE);

  assign neg1_in = op_signed1(SELECT[4:2]) && DATA1[31];
  assign neg2_in = op_signed2(SELECT[4:2]) && DATA2[31];
  assign mag1_in = neg1_in ? (~DATA1 + 32'd1) : DATA1;
  assign mag2_in = neg2_in ? (~DATA2 + 32'd1) : DATA2;

  assign mode = func3_q[2] ? STEP_DIV : STEP_MUL;

  muldiv_step u_step (
    .mode     (mode),
    .acc      (acc_q),
    .low      (low_q),
    .operand  (op_q),
    .acc_next (acc_n),
    .low_next (low_n)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (count_q == 5'd31) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = accept ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign BUSY      = (state_q == S_CALC) || (state_q == S_FIX);
  assign DONE      = (state_q == S_DONE);
  assign dbg_state = state_q;

  // Sign fix-up and special cases, applied to the unsigned iteration result.
  logic [63:0] prod, prod_s;
  logic [31:0] quo_s, rem_s;
  logic        div_zero, div_ovf;

  always_comb begin
    prod       = {acc_q, low_q};
    prod_s     = (neg1_q ^ neg2_q) ? (~prod + 64'd1) : prod;
    quo_s      = (neg1_q ^ neg2_q) ? (~low_q + 32'd1) : low_q;
    rem_s      = neg1_q ? (~acc_q + 32'd1) : acc_q;
    div_zero   = (b_q == 32'd0);
    div_ovf    = !func3_q[0] && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    fix_result = '0;
    unique case (func3_q)
      F3_MUL:    fix_result = prod_s[31:0];
      F3_MULH,
      F3_MULHSU,
      F3_MULHU:  fix_result = prod_s[63:32];
      F3_DIV:    fix_result = div_zero ? 32'hFFFF_FFFF : (div_ovf ? 32'h8000_0000 : quo_s);
      F3_DIVU:   fix_result = div_zero ? 32'hFFFF_FFFF : low_q;
      F3_REM:    fix_result = div_zero ? a_q : (div_ovf ? 32'd0 : rem_s);
      F3_REMU:   fix_result = div_zero ? a_q : acc_q;
      default:   fix_result = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
      func3_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      RESULT  <= '0;
    end else begin
      if (accept) begin
        count_q <= '0;
        func3_q <= SELECT[4:2];
        a_q     <= DATA1;
        b_q     <= DATA2;
        neg1_q  <= neg1_in;
        neg2_q  <= neg2_in;
        acc_q   <= '0;
        // Divide iterates on the dividend; multiply shifts the multiplier out of the low half.
        if (SELECT[4]) begin
          low_q <= mag1_in;
          op_q  <= mag2_in;
        end else begin
          low_q <= mag2_in;
          op_q  <= mag1_in;
        end
      end else if (state_q == S_CALC) begin
        acc_q   <= acc_n;
        low_q   <= low_n;
        count_q <= count_q + 5'd1;
      end
      if (state_q == S_FIX) RESULT <= fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, handshake corner cases and random ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  sel = '0;
  logic [31:0] d1 = '0, d2 = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int EXP_LAT  = 34;
  localparam int EXP_BUSY = 33;

  muldiv_unit dut (
    .CLK(clk), .RESET(rst), .START(start), .SELECT(sel), .DATA1(d1), .DATA2(d2),
    .BUSY(busy), .DONE(done), .RESULT(result), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model from the RV32M rules using plain wide arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    case (s[4:2])
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Presents a request for one edge, then drops START and scrambles the operand inputs.
  task automatic start_op(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    sel   = s;
    d1    = a;
    d2    = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sel   = {3'($urandom_range(0, 7)), 2'b10};
    d1    = $urandom;
    d2    = $urandom;
  endtask

  // Called in the cycle after the accepting edge; lat counts cycles from that edge to DONE.
  task automatic wait_done(output logic [31:0] res, output int lat, output int busy_n, output bit stable);
    logic [31:0] r0;
    lat    = 0;
    busy_n = 0;
    stable = 1'b1;
    res    = 'x;
    r0     = result;
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      if (done) begin
        lat = i;
        res = result;
        break;
      end
      if (busy) busy_n++;
      if (result !== r0) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got=%0b want=0", done); end
    n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [4:0]  s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t v[14];
    logic [31:0] res;
    int lat, busy_n;
    bit stable;
    v[0]  = '{SEL_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    v[1]  = '{SEL_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    v[2]  = '{SEL_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[3]  = '{SEL_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    v[4]  = '{SEL_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    v[5]  = '{SEL_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    v[6]  = '{SEL_DIVU,   32'd100,        32'd7,         32'd14};
    v[7]  = '{SEL_REMU,   32'd100,        32'd7,         32'd2};
    v[8]  = '{SEL_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
    v[9]  = '{SEL_REM,    32'd5,          32'd0,         32'd5};
    v[10] = '{SEL_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
    v[11] = '{SEL_REMU,   32'd5,          32'd0,         32'd5};
    v[12] = '{SEL_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    v[13] = '{SEL_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    foreach (v[i]) begin
      start_op(v[i].s, v[i].a, v[i].b);
      wait_done(res, lat, busy_n, stable);
      n_cmp++; if (res !== v[i].exp) begin n_fail++; $display("FAIL directed_%0d_result got=%h want=%h", i, res, v[i].exp); end
      n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat, EXP_LAT); end
      n_cmp++; if (busy_n != EXP_BUSY) begin n_fail++; $display("FAIL directed_%0d_busy_cycles got=%0d want=%0d", i, busy_n, EXP_BUSY); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res1, res2, exp1, exp2;
    int lat, busy_n;
    bit stable;
    exp1 = ref_model(SEL_MUL, 32'd12345, 32'd678);
    exp2 = ref_model(SEL_DIV, 32'hFFFF_0000, 32'd3);
    start_op(SEL_MUL, 32'd12345, 32'd678);
    wait_done(res1, lat, busy_n, stable);
    n_cmp++; if (res1 !== exp1) begin n_fail++; $display("FAIL b2b_first_result got=%h want=%h", res1, exp1); end
    start_op(SEL_DIV, 32'hFFFF_0000, 32'd3);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap_busy got=%0b want=1", busy); end
    wait_done(res2, lat, busy_n, stable);
    n_cmp++; if (!stable) begin n_fail++; $display("FAIL b2b_result_stable got=changed want=held"); end
    n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL b2b_latency got=%0d want=%0d", lat, EXP_LAT); end
    n_cmp++; if (res2 !== exp2) begin n_fail++; $display("FAIL b2b_second_result got=%h want=%h", res2, exp2); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    logic [31:0] exp, res;
    int lat;
    exp = ref_model(SEL_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    start_op(SEL_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    lat = 0;
    res = 'x;
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end
      if (done) begin
        lat = i;
        res = result;
        break;
      end
      if (i == 5) begin
        start = 1'b1; sel = SEL_DIVU; d1 = 32'd99; d2 = 32'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL busy_start_latency got=%0d want=%0d", lat, EXP_LAT); end
    n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL busy_start_result got=%h want=%h", res, exp); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_not_queued got=%0b want=0", busy); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL busy_start_idle_state got=%0d want=0", dbg_state); end
  endtask

  task automatic test_invalid_code();
    int seen;
    sel = 5'b000_00; d1 = 32'd1; d2 = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy || done) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL invalid_code_activity got=%0d want=0", seen); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res, exp;
    int lat, busy_n, dones;
    bit stable;
    start_op(SEL_DIV, 32'h7654_3210, 32'd17);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    start = 1'b1; sel = SEL_MUL; d1 = 32'd3; d2 = 32'd4;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL midreset_busy got=%0b want=0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_fail++; $display("FAIL midreset_done got=%0b want=0", done); end
    n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL midreset_result got=%h want=0", result); end
    rst = 1'b0;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dones++;
      @(posedge clk); #1;
    end
    n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d want=0", dones); end
    exp = ref_model(SEL_MUL, 32'hFFFF_FFF0, 32'd33);
    start_op(SEL_MUL, 32'hFFFF_FFF0, 32'd33);
    wait_done(res, lat, busy_n, stable);
    n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL post_reset_mul got=%h want=%h", res, exp); end
    n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL post_reset_latency got=%0d want=%0d", lat, EXP_LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [4:0] s;
    logic [31:0] a, b, res, exp;
    int lat, busy_n;
    bit stable;
    for (int n = 0; n < 40; n++) begin
      s = {3'($urandom_range(0, 7)), 2'b10};
      a = pick_operand();
      b = pick_operand();
      exp = ref_model(s, a, b);
      start_op(s, a, b);
      wait_done(res, lat, busy_n, stable);
      n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL random_%0d sel=%b a=%h b=%h got=%h want=%h", n, s, a, b, res, exp); end
      n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL random_%0d_latency got=%0d want=%0d", n, lat, EXP_LAT); end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_while_busy();
    test_invalid_code();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
